// File: rtl/alarm_controller.sv
// Single-alarm controller with snooze/stop/timeout fed by the 12-hour clock outputs.
// Optional top-of-hour chime is built only when ALARM_CHIME_EN is defined.
module alarm_controller #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic [3:0] hours,
  input  logic       alarm_en,
  input  logic       set_valid,
  input  logic [3:0] set_hours,
  input  logic [5:0] set_minutes,
  output logic       set_ready,
  output logic       set_err,
  input  logic       snooze,
  input  logic       stop,
  output logic       ring,
  output logic [3:0] alarm_hours,
  output logic [5:0] alarm_minutes,
  output logic [2:0] snooze_left,
  output logic       chime
);

  typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} state_e;

  localparam logic [8:0] RING_LAST   = 9'(RING_SECONDS - 1);
  localparam logic [8:0] SNOOZE_LAST = 9'(SNOOZE_SECONDS - 1);
  localparam logic [2:0] SNOOZE_MAX  = 3'(MAX_SNOOZE);

  state_e     state_q, state_d;
  logic [5:0] seconds_q;
  logic [3:0] alarm_hours_q, alarm_hours_d;
  logic [5:0] alarm_minutes_q, alarm_minutes_d;
  logic       alarm_set_q, alarm_set_d;
  logic [2:0] snooze_left_q, snooze_left_d;
  logic [8:0] ring_cnt_q, ring_cnt_d;
  logic [8:0] snz_cnt_q, snz_cnt_d;
  logic       ring_q, ring_d;
  logic       set_err_q, set_err_d;

  logic sec_tick, match, set_accept, set_in_range;

  assign sec_tick     = (seconds != seconds_q);
  // Compared against the stored time, so a same-cycle load cannot affect this match.
  assign match        = sec_tick && (seconds == 6'd0) &&
                        (hours == alarm_hours_q) && (minutes == alarm_minutes_q);
  assign set_ready    = (state_q == IDLE) || (state_q == ARMED);
  assign set_accept   = set_valid && set_ready;
  assign set_in_range = (set_hours <= 4'd11) && (set_minutes <= 6'd59);

  always_comb begin
    state_d         = state_q;
    alarm_hours_d   = alarm_hours_q;
    alarm_minutes_d = alarm_minutes_q;
    alarm_set_d     = alarm_set_q;
    snooze_left_d   = snooze_left_q;
    ring_cnt_d      = ring_cnt_q;
    snz_cnt_d       = snz_cnt_q;
    set_err_d       = set_accept && !set_in_range;

    if (set_accept && set_in_range) begin
      alarm_hours_d   = set_hours;
      alarm_minutes_d = set_minutes;
      alarm_set_d     = 1'b1;
    end

    if (!alarm_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (alarm_set_q) state_d = ARMED;
        ARMED: begin
          if (match) begin
            state_d       = RINGING;
            ring_cnt_d    = '0;
            snooze_left_d = SNOOZE_MAX;
          end
        end
        RINGING: begin
          if (stop) begin
            state_d = ARMED;
          end else if (snooze && (snooze_left_q != 3'd0)) begin
            state_d       = SNOOZE;
            snooze_left_d = snooze_left_q - 3'd1;
            snz_cnt_d     = '0;
          end else if (sec_tick) begin
            if (ring_cnt_q == RING_LAST) state_d = ARMED;
            else                         ring_cnt_d = ring_cnt_q + 9'd1;
          end
        end
        SNOOZE: begin
          if (stop) begin
            state_d = ARMED;
          end else if (sec_tick) begin
            if (snz_cnt_q == SNOOZE_LAST) begin
              state_d    = RINGING;
              ring_cnt_d = '0;
            end else begin
              snz_cnt_d = snz_cnt_q + 9'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    ring_d = (state_d == RINGING);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      seconds_q       <= '0;
      alarm_hours_q   <= '0;
      alarm_minutes_q <= '0;
      alarm_set_q     <= 1'b0;
      snooze_left_q   <= SNOOZE_MAX;
      ring_cnt_q      <= '0;
      snz_cnt_q       <= '0;
      ring_q          <= 1'b0;
      set_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      seconds_q       <= seconds;
      alarm_hours_q   <= alarm_hours_d;
      alarm_minutes_q <= alarm_minutes_d;
      alarm_set_q     <= alarm_set_d;
      snooze_left_q   <= snooze_left_d;
      ring_cnt_q      <= ring_cnt_d;
      snz_cnt_q       <= snz_cnt_d;
      ring_q          <= ring_d;
      set_err_q       <= set_err_d;
    end
  end

  assign ring          = ring_q;
  assign set_err       = set_err_q;
  assign alarm_hours   = alarm_hours_q;
  assign alarm_minutes = alarm_minutes_q;
  assign snooze_left   = snooze_left_q;

`ifdef ALARM_CHIME_EN
  logic chime_q, chime_d;
  assign chime_d = sec_tick && (seconds == 6'd0) && (minutes == 6'd0);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) chime_q <= 1'b0;
    else      chime_q <= chime_d;
  end
  assign chime = chime_q;
`else
  assign chime = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_controller.sv
// Directed + randomized bench for alarm_controller against a countdown-style reference model.
module tb_alarm_controller;
  localparam int RS = 60, SS = 300, MS = 3;

  logic       clk = 1'b0, rst;
  logic [5:0] seconds, minutes;
  logic [3:0] hours;
  logic       alarm_en, set_valid, snooze, stop;
  logic [3:0] set_hours;
  logic [5:0] set_minutes;
  logic       set_ready, set_err, ring, chime;
  logic [3:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic [2:0] snooze_left;

  alarm_controller #(.RING_SECONDS(RS), .SNOOZE_SECONDS(SS), .MAX_SNOOZE(MS)) dut (
    .clk(clk), .rst(rst), .seconds(seconds), .minutes(minutes), .hours(hours),
    .alarm_en(alarm_en), .set_valid(set_valid), .set_hours(set_hours),
    .set_minutes(set_minutes), .set_ready(set_ready), .set_err(set_err),
    .snooze(snooze), .stop(stop), .ring(ring), .alarm_hours(alarm_hours),
    .alarm_minutes(alarm_minutes), .snooze_left(snooze_left), .chime(chime)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Model: mode 0=off, 1=waiting for alarm time, 2=sounding, 3=dozing.
  int m_mode, m_ring_left, m_doze_left, m_snz, m_ah, m_am, m_prev_sec;
  bit m_set, m_err, m_chime;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_snz = MS; m_ah = 0; m_am = 0; m_set = 0;
    m_err = 0; m_chime = 0; m_prev_sec = 0; m_ring_left = 0; m_doze_left = 0;
  endtask

  task automatic model_step();
    bit tick, match, old_set;
    tick    = (int'(seconds) != m_prev_sec);
    m_prev_sec = int'(seconds);
    match   = tick && seconds == 0 && int'(hours) == m_ah && int'(minutes) == m_am;
    old_set = m_set;
    m_err   = 0;
    if (set_valid && (m_mode == 0 || m_mode == 1)) begin
      if (set_hours > 11 || set_minutes > 59) m_err = 1;
      else begin m_ah = int'(set_hours); m_am = int'(set_minutes); m_set = 1; end
    end
`ifdef ALARM_CHIME_EN
    m_chime = tick && seconds == 0 && minutes == 0;
`else
    m_chime = 0;
`endif
    if (!alarm_en) m_mode = 0;
    else if (m_mode == 0) begin
      if (old_set) m_mode = 1;
    end else if (m_mode == 1) begin
      if (match) begin m_mode = 2; m_ring_left = RS; m_snz = MS; end
    end else if (m_mode == 2) begin
      if (stop) m_mode = 1;
      else if (snooze && m_snz > 0) begin m_mode = 3; m_snz--; m_doze_left = SS; end
      else if (tick) begin m_ring_left--; if (m_ring_left == 0) m_mode = 1; end
    end else begin
      if (stop) m_mode = 1;
      else if (tick) begin
        m_doze_left--;
        if (m_doze_left == 0) begin m_mode = 2; m_ring_left = RS; end
      end
    end
  endtask

  task automatic check_all();
    chk("ring", ring, 32'(m_mode == 2));
    chk("set_ready", set_ready, 32'(m_mode < 2));
    chk("set_err", set_err, 32'(m_err));
    chk("alarm_hours", alarm_hours, m_ah);
    chk("alarm_minutes", alarm_minutes, m_am);
    chk("snooze_left", snooze_left, m_snz);
    chk("chime", chime, 32'(m_chime));
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_time(int h, int m, int s);
    hours = 4'(h); minutes = 6'(m); seconds = 6'(s);
    cyc();
  endtask

  task automatic adv(int n);
    for (int i = 0; i < n; i++) begin
      if (seconds == 59) begin
        seconds = 0;
        if (minutes == 59) begin
          minutes = 0;
          hours = (hours == 11) ? 4'd0 : hours + 4'd1;
        end else minutes = minutes + 6'd1;
      end else seconds = seconds + 6'd1;
      cyc();
    end
  endtask

  task automatic load(int h, int m);
    set_valid = 1; set_hours = 4'(h); set_minutes = 6'(m);
    cyc();
    set_valid = 0;
  endtask

  task automatic pulse_snooze();
    snooze = 1; cyc(); snooze = 0;
  endtask

  task automatic pulse_stop();
    stop = 1; cyc(); stop = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 0; seconds = 0; minutes = 0; hours = 0; alarm_en = 0;
    set_valid = 0; set_hours = 0; set_minutes = 0; snooze = 0; stop = 0;
    model_reset();
    #12 rst = 1;
    chk("rst_ring", ring, 0);
    chk("rst_snooze_left", snooze_left, 3);
    chk("rst_set_ready", set_ready, 1);
    chk("rst_alarm_hours", alarm_hours, 0);

    // Load 7:30, ring on the minute, auto-timeout after 60 s
    alarm_en = 1;
    load(7, 30);
    cyc(); cyc();
    set_time(7, 29, 50);
    adv(10);
    chk("ring_at_match", ring, 1);
    adv(59);
    chk("ring_before_timeout", ring, 1);
    adv(1);
    chk("ring_timeout", ring, 0);

    // Snooze three times, fourth snooze ignored, then stop
    set_time(7, 29, 59);
    set_time(7, 30, 0);
    for (int k = 0; k < MS; k++) begin
      pulse_snooze();
      chk("snooze_ring_off", ring, 0);
      chk("snooze_count", snooze_left, 32'(MS - 1 - k));
      adv(SS - 1);
      chk("snooze_still_off", ring, 0);
      adv(1);
      chk("snooze_rering", ring, 1);
    end
    pulse_snooze();
    chk("snooze_exhausted_ring", ring, 1);
    chk("snooze_exhausted_left", snooze_left, 0);
    pulse_stop();
    chk("stop_ring", ring, 0);

    // Range-checked loads and set held off while ringing
    load(12, 10);
    chk("err_pulse", set_err, 1);
    chk("err_keeps_hours", alarm_hours, 7);
    cyc();
    chk("err_single_cycle", set_err, 0);
    load(11, 59);
    chk("load_hours", alarm_hours, 11);
    chk("load_minutes", alarm_minutes, 59);
    set_time(11, 58, 59);
    set_time(11, 59, 0);
    set_valid = 1; set_hours = 3; set_minutes = 15;
    cyc(); cyc(); cyc();
    chk("held_not_taken", alarm_hours, 11);
    stop = 1; cyc(); stop = 0;
    chk("held_after_stop", alarm_hours, 11);
    cyc();
    set_valid = 0;
    chk("held_taken_h", alarm_hours, 3);
    chk("held_taken_m", alarm_minutes, 15);

    // Stop beats snooze; disarm during snooze
    set_time(3, 14, 59);
    set_time(3, 15, 0);
    snooze = 1; stop = 1; cyc(); snooze = 0; stop = 0;
    chk("stop_over_snooze_ring", ring, 0);
    chk("stop_over_snooze_left", snooze_left, 3);
    set_time(3, 14, 59);
    set_time(3, 15, 0);
    pulse_snooze();
    adv(10);
    alarm_en = 0;
    cyc();
    chk("disarm_ready", set_ready, 1);
    adv(SS);
    chk("disarm_no_rering", ring, 0);
    alarm_en = 1;
    cyc(); cyc();

    // Asynchronous reset while ringing
    set_time(3, 14, 59);
    set_time(3, 15, 0);
    chk("pre_reset_ring", ring, 1);
    seconds = 0;
    #2 rst = 0;
    #1;
    chk("async_rst_ring", ring, 0);
    chk("async_rst_hours", alarm_hours, 0);
    chk("async_rst_minutes", alarm_minutes, 0);
    chk("async_rst_snooze_left", snooze_left, 3);
    chk("async_rst_set_ready", set_ready, 1);
    model_reset();
    #2 rst = 1;

    // Top-of-hour chime
    set_time(10, 59, 59);
    set_time(11, 0, 0);
`ifdef ALARM_CHIME_EN
    chk("chime_pulse", chime, 1);
`else
    chk("chime_pulse", chime, 0);
`endif
    cyc();
    chk("chime_single", chime, 0);

    // Randomized traffic
    load(int'($urandom_range(0, 11)), int'($urandom_range(0, 59)));
    for (int i = 0; i < 4000; i++) begin
      alarm_en  = ($urandom_range(0, 199) != 0);
      snooze    = ($urandom_range(0, 99) < 4);
      stop      = ($urandom_range(0, 99) < 2);
      set_valid = ($urandom_range(0, 99) < 3);
      set_hours = 4'($urandom_range(0, 15));
      set_minutes = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 299) == 0) set_time(m_ah, m_am, 0);
      else if ($urandom_range(0, 1) == 1) adv(1);
      else cyc();
    end
    snooze = 0; stop = 0; set_valid = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Downstream consumer of the digital clock's seconds/minutes/hours outputs (12-hour count, hours 0..11).
- Holds one programmable alarm time and raises ring at the matching minute.
- Supports snooze with a bounded repeat count, stop, and automatic ring timeout.
- Drives the buzzer/LED stage; the alarm time is loaded through a valid/ready set port.

Parameters:
RING_SECONDS, 60, seconds ring stays high before auto-timeout (1..511)
SNOOZE_SECONDS, 300, seconds spent in SNOOZE before re-ringing (1..511)
MAX_SNOOZE, 3, snoozes allowed per alarm event (1..7)

Ports:
clk  input  1  system clock, same clock as the digital clock
rst  input  1  asynchronous, active-low reset (asserted when 0)
seconds  input  6  current seconds, 0..59
minutes  input  6  current minutes, 0..59
hours  input  4  current hours, 0..11
alarm_en  input  1  level; 0 disarms and silences the alarm
set_valid  input  1  alarm-time load request
set_hours  input  4  requested alarm hour
set_minutes  input  6  requested alarm minute
set_ready  output  1  load accepted when set_valid && set_ready
set_err  output  1  1-cycle pulse when a load is rejected as out of range
snooze  input  1  1-cycle pulse from the snooze button
stop  input  1  1-cycle pulse from the stop button
ring  output  1  alarm sounding
alarm_hours  output  4  stored alarm hour
alarm_minutes  output  6  stored alarm minute
snooze_left  output  3  remaining snoozes for the current event
chime  output  1  top-of-hour pulse (see Optional Feature)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, ring=0, set_err=0, chime=0, alarm_hours=0, alarm_minutes=0, snooze_left=MAX_SNOOZE, alarm_set=0, seconds_q=0, all counters 0.
- sec_tick = (seconds != seconds_q). seconds_q is registered every cycle, so sec_tick is high for exactly one cycle per seconds change.
- match = sec_tick && seconds==0 && hours==alarm_hours && minutes==alarm_minutes.
  - Fires once per matching minute.
- Set handshake:
  - set_ready=1 in IDLE and ARMED; 0 in RINGING and SNOOZE.
  - On accept, if set_hours>11 or set_minutes>59: set_err pulses high the next cycle and the stored values are unchanged.
  - Otherwise the values are stored the next cycle and alarm_set=1.
  - Valid data may be held indefinitely while set_ready=0.
- States:
  - IDLE -> ARMED when alarm_en && alarm_set.
  - ARMED -> RINGING on match. ring=1 from the cycle after match. ring_cnt clears; snooze_left reloads to MAX_SNOOZE.
  - RINGING:
    - stop -> ARMED, ring=0 next cycle.
    - snooze with snooze_left>0 -> SNOOZE, snooze_left-1, snz_cnt cleared, ring=0.
    - snooze with snooze_left==0 is ignored.
    - ring_cnt increments on sec_tick. At ring_cnt==RING_SECONDS-1 together with sec_tick -> ARMED, ring=0.
  - SNOOZE:
    - snz_cnt increments on sec_tick. At SNOOZE_SECONDS-1 together with sec_tick -> RINGING, ring_cnt cleared.
    - stop -> ARMED.
- alarm_en=0 in any state -> IDLE next cycle, ring=0. Stored time is kept.
- Priority in the same cycle: alarm_en=0 > stop > snooze > timeout/expiry.
- A set accepted in ARMED in the same cycle as match: the match is evaluated against the old stored time; the new time takes effect the next cycle.
- The alarm is not re-armed for the same minute after a stop: match requires the seconds==0 tick, which occurs only once per minute.
- ring, set_err and chime are registered outputs. No combinational path runs from inputs to outputs, except set_ready, which is a decode of the state register.
- ring_cnt and snz_cnt are 9 bits wide.

Optional Feature:
ALARM_CHIME_EN
- Defined: chime is a 1-cycle registered pulse the cycle after any sec_tick with seconds==0 and minutes==0, independent of alarm state and alarm_en.
- Not defined: chime is tied to 0 and no chime logic is present. The port always exists.

Test Plan:
1. Reset: drive rst=0 mid-ring -> ring=0, alarm_hours=0, alarm_minutes=0, snooze_left=3, set_ready=1 immediately (asynchronous).
2. Load 7:30, alarm_en=1. Run the clock to 7:29:59 -> 7:30:00 -> ring=1 one cycle later. Hold 60 seconds with no input -> ring=0, state ARMED.
3. Ringing; pulse snooze -> ring=0, snooze_left=2. After 300 sec_ticks -> ring=1. Repeat twice more -> snooze_left=0. Further snooze is ignored and ring stays 1. Pulse stop -> ring=0.
4. Load set_hours=12, set_minutes=10 -> set_err pulse, stored time unchanged. Load 11:59 -> accepted. Hold set_valid during RINGING -> not accepted until after stop.
5. Same-cycle stop+snooze while RINGING -> ARMED, snooze_left unchanged. alarm_en=0 while in SNOOZE -> IDLE, ring stays 0 at snooze expiry.
6. With ALARM_CHIME_EN: 10:59:59 -> 11:00:00 gives exactly one chime cycle. Without it, chime stays 0 throughout.
